// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus: ROM address/data plus the decode valid/ready handshake and
// the execute redirect request.
interface instr_fetch_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] douta;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;

  modport master (
    output addra, instr, instr_pc, instr_valid,
    input  douta, instr_ready, redirect_valid, redirect_addr
  );

  modport slave (
    input  addra, instr, instr_pc, instr_valid,
    output douta, instr_ready, redirect_valid, redirect_addr
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer for KGP-RISC: owns the PC, drives the
// synchronous instruction ROM and presents fetched words to decode.
module instr_fetch_ctrl #(
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  instr_fetch_ctrl_if.master bus,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            cur;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] f1_pc;
  logic              f1_valid;
  logic              xfer;
  logic              issue;
  logic [DATA_W-1:0] word;

  assign word            = bus.douta;
  assign bus.instr       = word;
  assign bus.instr_pc    = f1_pc;
  assign bus.instr_valid = f1_valid & ~bus.redirect_valid & (cur == RUN);
  assign xfer            = bus.instr_valid & bus.instr_ready;
  assign issue           = ~f1_valid | xfer;
  assign state           = cur;

  // Holding on f1_pc makes the ROM re-read the presented word, so instr stays stable.
  always_comb begin
    bus.addra = f1_pc;
    case (cur)
      IDLE: bus.addra = pc;
      RUN: begin
        if (halt_req)
          bus.addra = f1_pc;
        else if (bus.redirect_valid)
          bus.addra = bus.redirect_addr;
        else if (issue)
          bus.addra = pc;
        else
          bus.addra = f1_pc;
      end
      default: bus.addra = f1_pc;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      cur         <= IDLE;
      pc          <= RESET_PC;
      f1_pc       <= RESET_PC;
      f1_valid    <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (xfer && (fetch_count != '1))
        fetch_count <= fetch_count + CNT_W'(1);

      case (cur)
        IDLE: begin
          f1_valid <= 1'b0;
          if (bus.redirect_valid)
            pc <= bus.redirect_addr;
          if (start)
            cur <= RUN;
        end
        RUN: begin
          if (halt_req) begin
            cur      <= HALT;
            f1_valid <= 1'b0;
          end else if (bus.redirect_valid) begin
            f1_pc    <= bus.redirect_addr;
            f1_valid <= 1'b1;
            pc       <= bus.redirect_addr + ADDR_W'(1);
          end else if (issue) begin
            f1_pc    <= pc;
            f1_valid <= 1'b1;
            pc       <= pc + ADDR_W'(1);
          end
        end
        HALT: begin
          f1_valid <= 1'b0;
        end
        default: begin
          cur      <= IDLE;
          f1_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a behavioural ROM holding 0xA000_0000+i,
// a per-cycle vector table and a long run to reach counter saturation.
module tb_instr_fetch_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef struct {
    logic              rst;
    logic              start;
    logic              halt;
    logic              redir;
    logic [ADDR_W-1:0] raddr;
    logic              ready;
    logic              ev;
    logic [ADDR_W-1:0] epc;
    logic [ADDR_W-1:0] ea;
    logic [1:0]        es;
    logic [CNT_W-1:0]  ec;
  } vec_t;

  logic             clka = 1'b0;
  logic             rst;
  logic             start;
  logic             halt_req;
  logic [1:0]       state;
  logic [CNT_W-1:0] fetch_count;

  int tests    = 0;
  int failures = 0;
  int step     = 0;

  vec_t vecs[$];

  instr_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instr_fetch_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(10'd0),
    .CNT_W   (CNT_W)
  ) dut (
    .clka       (clka),
    .rst        (rst),
    .start      (start),
    .halt_req   (halt_req),
    .bus        (bus),
    .state      (state),
    .fetch_count(fetch_count)
  );

  always #5 clka = ~clka;

  // One-cycle synchronous ROM with ROM[i] = 0xA000_0000 + i.
  always @(posedge clka)
    bus.douta <= 32'hA000_0000 | 32'(bus.addra);

  function automatic vec_t mk(
    input logic r, input logic s, input logic h, input logic d,
    input logic [ADDR_W-1:0] ra, input logic rdy,
    input logic ev, input logic [ADDR_W-1:0] epc, input logic [ADDR_W-1:0] ea,
    input logic [1:0] es, input logic [CNT_W-1:0] ec);
    vec_t v;
    v.rst = r; v.start = s; v.halt = h; v.redir = d; v.raddr = ra; v.ready = rdy;
    v.ev = ev; v.epc = epc; v.ea = ea; v.es = es; v.ec = ec;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst                = v.rst;
    start              = v.start;
    halt_req           = v.halt;
    bus.redirect_valid = v.redir;
    bus.redirect_addr  = v.raddr;
    bus.instr_ready    = v.ready;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s step %0d: got %h, expected %h", name, step, act, exp);
    end
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;

    //           rst s h d raddr   rdy | ev epc     ea      es ec
    vecs.push_back(mk(0,0,0,0,10'h000,1, 0,10'h000,10'h000,0,0));
    vecs.push_back(mk(0,1,0,0,10'h000,1, 0,10'h000,10'h000,0,0));
    vecs.push_back(mk(0,0,0,0,10'h000,1, 0,10'h000,10'h000,1,0));
    vecs.push_back(mk(0,0,0,0,10'h000,1, 1,10'h000,10'h001,1,0));
    vecs.push_back(mk(0,0,0,0,10'h000,1, 1,10'h001,10'h002,1,1));
    vecs.push_back(mk(0,0,0,0,10'h000,0, 1,10'h002,10'h002,1,2));
    vecs.push_back(mk(0,0,0,0,10'h000,0, 1,10'h002,10'h002,1,2));
    vecs.push_back(mk(0,0,0,0,10'h000,0, 1,10'h002,10'h002,1,2));
    vecs.push_back(mk(0,0,0,0,10'h000,1, 1,10'h002,10'h003,1,2));
    vecs.push_back(mk(0,0,0,0,10'h000,1, 1,10'h003,10'h004,1,3));
    vecs.push_back(mk(0,0,0,0,10'h000,1, 1,10'h004,10'h005,1,4));
    vecs.push_back(mk(0,0,0,1,10'h100,1, 0,10'h000,10'h100,1,5));
    vecs.push_back(mk(0,0,0,0,10'h000,1, 1,10'h100,10'h101,1,5));
    vecs.push_back(mk(0,0,0,0,10'h000,1, 1,10'h101,10'h102,1,6));
    vecs.push_back(mk(0,0,0,1,10'h3FF,1, 0,10'h000,10'h3FF,1,7));
    vecs.push_back(mk(0,0,0,0,10'h000,1, 1,10'h3FF,10'h000,1,7));
    vecs.push_back(mk(0,0,0,0,10'h000,1, 1,10'h000,10'h001,1,8));
    vecs.push_back(mk(0,0,0,0,10'h000,1, 1,10'h001,10'h002,1,9));
    vecs.push_back(mk(0,0,0,1,10'h007,1, 0,10'h000,10'h007,1,10));
    vecs.push_back(mk(0,0,1,0,10'h000,1, 1,10'h007,10'h007,1,10));
    vecs.push_back(mk(0,1,0,1,10'h055,1, 0,10'h000,10'h007,2,11));
    vecs.push_back(mk(0,0,0,0,10'h000,1, 0,10'h000,10'h007,2,11));
    vecs.push_back(mk(1,1,0,0,10'h000,1, 0,10'h000,10'h007,2,11));
    vecs.push_back(mk(0,0,0,0,10'h000,1, 0,10'h000,10'h000,0,0));
    vecs.push_back(mk(1,1,0,0,10'h000,1, 0,10'h000,10'h000,0,0));
    vecs.push_back(mk(0,0,0,0,10'h000,1, 0,10'h000,10'h000,0,0));
    vecs.push_back(mk(0,1,0,0,10'h000,1, 0,10'h000,10'h000,0,0));
    vecs.push_back(mk(0,0,0,0,10'h000,1, 0,10'h000,10'h000,1,0));
    vecs.push_back(mk(0,0,0,0,10'h000,0, 1,10'h000,10'h000,1,0));
    vecs.push_back(mk(0,0,1,1,10'h200,1, 0,10'h000,10'h000,1,0));
    vecs.push_back(mk(0,0,0,0,10'h000,1, 0,10'h000,10'h000,2,0));

    applyStimulus(mk(1,0,0,0,10'h000,0, 0,10'h000,10'h000,0,0));
    repeat (2) @(posedge clka);
    #1;

    foreach (vecs[i]) begin
      step = i;
      applyStimulus(vecs[i]);
      #4;
      checkOutput("state", 32'(state), 32'(vecs[i].es));
      checkOutput("instr_valid", 32'(bus.instr_valid), 32'(vecs[i].ev));
      checkOutput("addra", 32'(bus.addra), 32'(vecs[i].ea));
      checkOutput("fetch_count", 32'(fetch_count), 32'(vecs[i].ec));
      if (vecs[i].ev) begin
        checkOutput("instr_pc", 32'(bus.instr_pc), 32'(vecs[i].epc));
        checkOutput("instr", bus.instr, 32'hA000_0000 | 32'(vecs[i].epc));
      end
      @(posedge clka);
      #1;
    end

    // Long run with ready held high: the counter must stop at all-ones.
    step = 1000;
    applyStimulus(mk(1,0,0,0,10'h000,1, 0,10'h000,10'h000,0,0));
    @(posedge clka); #1;
    start = 1'b0; rst = 1'b0; start = 1'b1;
    @(posedge clka); #1;
    start = 1'b0;
    n = 0;
    while (fetch_count !== 16'hFFFF && n < 70000) begin
      @(posedge clka); #1;
      n++;
    end
    checkOutput("sat_cycles", 32'(n), 32'd65536);
    checkOutput("sat_reach", 32'(fetch_count), 32'h0000_FFFF);
    repeat (5) @(posedge clka);
    #1;
    checkOutput("sat_hold", 32'(fetch_count), 32'h0000_FFFF);
    checkOutput("sat_valid", 32'(bus.instr_valid), 32'd1);
    checkOutput("sat_state", 32'(state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
